misao: RTL and testbench
========================

MISAO -- requirements
Module: misao

Interface
REQ-001 Parameters: none; all sizes fixed.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 mem_enable_read  out  1  1 every non-reset cycle, 0 during reset.
REQ-005 mem_enable_write  out  1  constant 0 (no store instructions).
REQ-006 mem_data_in  in  8  byte at mem_addr, combinational (asynchronous) read, consumed same cycle.
REQ-007 mem_addr  out  15  byte program counter PC.
REQ-008 mem_rw  out  1  constant 0 (read).
REQ-009 mem_data_out  out  8  ACC[7:0].
REQ-010 test_data  out  16  ACC.
REQ-011 test_carry  out  1  carry flag C.

Function
REQ-012 One byte per clock: low nibble is slot 0 and is executed first, high nibble is slot 1; both slots resolve combinationally, and results commit at the edge ending the cycle; PC increments by 1 and wraps 0x7FFF->0.
REQ-013 State: ACC[15:0], RS0[15:0], C, CFG[7:0], XOP-pending flag, LDI-remaining count (0-4), CFG-remaining count (0-2); all pending state carries across byte boundaries.
REQ-014 CFG[1:0] width W: 00 = UL (4), 01 = LK8 (8), 10/11 = LK16 (16); CFG[3] = CEN; other bits are stored and unused.
REQ-015 Base opcodes: 0 NOP, 1 XOP, 2 LDI, 3 SS, 4 ADD, 5 INC, 6 AND, 7 OR, 8 SHL, 9 CC; opcodes A-F are NOP.
REQ-016 XOP sets the pending flag, which modifies the next opcode nibble and then clears: ADD->SUB, INC->DEC, AND->INV, OR->XOR, SHL->SHR, CC->CFG; any other opcode executes as a NOP.
REQ-017 ALU ops act on ACC[W-1:0] with RS0[W-1:0] and zero-extend the result to 16 bits; there is never a carry-in.
REQ-018 ADD/INC: C = carry-out of bit W-1.
REQ-019 SUB (ACC-RS0) and DEC (ACC-1): with borrow-out b, C = b when CEN=1, and C = ~b when CEN=0.
REQ-020 AND/OR/XOR with RS0: C=0. INV: ACC=~ACC, C=~C.
REQ-021 SHL: C=ACC[W-1], logical shift left. SHR: C=ACC[0], logical shift right.
REQ-022 CC: C=0. SS: swap full 16-bit ACC and RS0, C unchanged. NOP: nothing.
REQ-023 LDI consumes the next W/4 nibbles as immediates, least-significant first.
REQ-024 The first LDI immediate clears ACC and writes ACC[3:0]; immediate k writes ACC[4k+3:4k]. Each nibble is visible at the end of its byte's cycle; C is unchanged.
REQ-025 CFG consumes the next 2 nibbles: the first becomes CFG[3:0], the second CFG[7:4]; it takes effect after the second nibble; C and ACC are unchanged.
REQ-026 Immediate and config nibbles are never decoded as opcodes; a pending XOP is not consumed by them.

Reset
REQ-027 While rst=1 at a rising edge: PC=0, ACC=0, RS0=0, C=0, CFG=0x00 (UL, CEN=0), and all pending state is cleared.
REQ-028 Reset mid-LDI or mid-CFG aborts the operation; the byte after release decodes as opcodes.

Configuration
REQ-029 Macro MISAO_LK16_EN.
REQ-030 Defined: CFG[1:0]=1x selects 16-bit mode.
REQ-031 Undefined: 1x behaves as LK8, ACC[15:8] and RS0[15:8] are forced 0, and LDI uses 2 immediates.

Verification
REQ-032 UL add chain: CFG 0x4C, LDI 5, SS, LDI 3, ADD x3 -> ACC 0x8, 0xD, 0x2, with C=1 after the third ADD; CC -> C=0; INC -> 0x3.
REQ-033 UL SUB borrow: ACC=3, RS0=5, CEN=1, XOP SUB -> ACC=0xE, C=1.
REQ-034 UL logic: RS0=0xC, ACC=0xA -> AND 0x8/C=0, OR 0xC, XOR 0x0, INV 0xF/C=1, SHL 0xE/C=1, SHR 0x7/C=0.
REQ-035 Wide mode, LK8:
- LDI F,F with ACC=0x0F after the first byte and 0xFF after the second.
- Then ADD with RS0=1 -> 0x0000, C=1.
REQ-036 Wide mode, LK16:
- LDI 1,0,0,0 -> 0x0001.
- LDI F,F,F,F -> 0xFFFF.
- ADD with RS0=1 and C=1 beforehand -> 0x0000, C=1.
- SHL 0x0001 -> 0x0002, then SHR -> 0x0001, C=0.
REQ-037 DEC/CEN: CFG 0x4C, ACC=3, DEC -> 2, C=0; CFG 0x44, DEC -> 1, C=1; reset during a LK16 LDI -> ACC=0, PC=0.

Source files
------------

// File: rtl/misao.sv
// MISAO: nibble-serial accumulator core that executes two 4-bit slots per fetched byte.
// Optional MISAO_LK16_EN enables the 16-bit LK16 width; when undefined the 1x width codes fall back to LK8.
module misao (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_enable_read,
    output logic        mem_enable_write,
    input  logic [7:0]  mem_data_in,
    output logic [14:0] mem_addr,
    output logic        mem_rw,
    output logic [7:0]  mem_data_out,
    output logic [15:0] test_data,
    output logic        test_carry
);

    typedef enum logic [1:0] {
        W_UL,
        W_LK8,
        W_LK16
    } width_e;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_XOP,
        OP_LDI,
        OP_SS,
        OP_ADD,
        OP_INC,
        OP_AND,
        OP_OR,
        OP_SHL,
        OP_CC,
        OP_SUB,
        OP_DEC,
        OP_INV,
        OP_XOR,
        OP_SHR,
        OP_CFG
    } op_e;

    // Architectural state plus the pending immediate/config sequencing.
    typedef struct packed {
        logic [15:0] acc;
        logic [15:0] rs0;
        logic        c;
        logic [7:0]  cfg;
        logic        xop;
        logic [2:0]  ldi_rem;
        logic [1:0]  ldi_idx;
        logic [1:0]  cfg_rem;
        logic [3:0]  cfg_lo;
    } core_t;

    core_t       cur;
    core_t       mid;
    core_t       nxt;
    logic [14:0] pc;

    function automatic width_e width_of(input logic [1:0] mode);
        width_e w;
        case (mode)
            2'b00:   w = W_UL;
            2'b01:   w = W_LK8;
`ifdef MISAO_LK16_EN
            default: w = W_LK16;
`else
            default: w = W_LK8;
`endif
        endcase
        return w;
    endfunction

    function automatic logic [15:0] width_mask(input width_e w);
        logic [15:0] m;
        case (w)
            W_UL:    m = 16'h000F;
            W_LK8:   m = 16'h00FF;
            default: m = 16'hFFFF;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] imm_count(input width_e w);
        logic [2:0] n;
        case (w)
            W_UL:    n = 3'd1;
            W_LK8:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Bit W of a 17-bit add/sub result is the carry-out (add) or borrow-out (sub).
    function automatic logic bit_w(input logic [16:0] r, input width_e w);
        logic b;
        case (w)
            W_UL:    b = r[4];
            W_LK8:   b = r[8];
            default: b = r[16];
        endcase
        return b;
    endfunction

    function automatic logic msb_of(input logic [15:0] a, input width_e w);
        logic b;
        case (w)
            W_UL:    b = a[3];
            W_LK8:   b = a[7];
            default: b = a[15];
        endcase
        return b;
    endfunction

    function automatic op_e decode(input logic xop, input logic [3:0] nib);
        op_e op;
        op = OP_NOP;
        if (!xop) begin
            case (nib)
                4'h1:    op = OP_XOP;
                4'h2:    op = OP_LDI;
                4'h3:    op = OP_SS;
                4'h4:    op = OP_ADD;
                4'h5:    op = OP_INC;
                4'h6:    op = OP_AND;
                4'h7:    op = OP_OR;
                4'h8:    op = OP_SHL;
                4'h9:    op = OP_CC;
                default: op = OP_NOP;
            endcase
        end else begin
            case (nib)
                4'h4:    op = OP_SUB;
                4'h5:    op = OP_DEC;
                4'h6:    op = OP_INV;
                4'h7:    op = OP_XOR;
                4'h8:    op = OP_SHR;
                4'h9:    op = OP_CFG;
                default: op = OP_NOP;
            endcase
        end
        return op;
    endfunction

    // One nibble slot: config/immediate nibbles take priority over opcode decode.
    function automatic core_t exec_slot(input core_t s, input logic [3:0] nib);
        core_t       n;
        width_e      w;
        logic [15:0] mask;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] wide;
        logic        cen;
        op_e         op;
        n    = s;
        w    = width_of(s.cfg[1:0]);
        mask = width_mask(w);
        a    = s.acc & mask;
        b    = s.rs0 & mask;
        cen  = s.cfg[3];
        wide = '0;
        if (s.cfg_rem != 2'd0) begin
            if (s.cfg_rem == 2'd2) begin
                n.cfg_lo  = nib;
                n.cfg_rem = 2'd1;
            end else begin
                n.cfg     = {nib, s.cfg_lo};
                n.cfg_rem = 2'd0;
            end
        end else if (s.ldi_rem != 3'd0) begin
            if (s.ldi_idx == 2'd0) begin
                n.acc = {12'h000, nib};
            end else begin
                n.acc[{s.ldi_idx, 2'b00} +: 4] = nib;
            end
            n.ldi_idx = s.ldi_idx + 2'd1;
            n.ldi_rem = s.ldi_rem - 3'd1;
        end else begin
            op    = decode(s.xop, nib);
            n.xop = 1'b0;
            case (op)
                OP_XOP: n.xop = 1'b1;
                OP_LDI: begin
                    n.ldi_rem = imm_count(w);
                    n.ldi_idx = 2'd0;
                end
                OP_SS: begin
                    n.acc = s.rs0;
                    n.rs0 = s.acc;
                end
                OP_ADD: begin
                    wide  = {1'b0, a} + {1'b0, b};
                    n.acc = wide[15:0] & mask;
                    n.c   = bit_w(wide, w);
                end
                OP_INC: begin
                    wide  = {1'b0, a} + 17'd1;
                    n.acc = wide[15:0] & mask;
                    n.c   = bit_w(wide, w);
                end
                // Borrow polarity follows CEN: direct borrow, or inverted (carry-style).
                OP_SUB: begin
                    wide  = {1'b0, a} - {1'b0, b};
                    n.acc = wide[15:0] & mask;
                    n.c   = cen ? bit_w(wide, w) : ~bit_w(wide, w);
                end
                OP_DEC: begin
                    wide  = {1'b0, a} - 17'd1;
                    n.acc = wide[15:0] & mask;
                    n.c   = cen ? bit_w(wide, w) : ~bit_w(wide, w);
                end
                OP_AND: begin
                    n.acc = a & b;
                    n.c   = 1'b0;
                end
                OP_OR: begin
                    n.acc = a | b;
                    n.c   = 1'b0;
                end
                OP_XOR: begin
                    n.acc = a ^ b;
                    n.c   = 1'b0;
                end
                OP_INV: begin
                    n.acc = ~a & mask;
                    n.c   = ~s.c;
                end
                OP_SHL: begin
                    n.c   = msb_of(a, w);
                    n.acc = (a << 1) & mask;
                end
                OP_SHR: begin
                    n.c   = a[0];
                    n.acc = a >> 1;
                end
                OP_CC:   n.c = 1'b0;
                OP_CFG:  n.cfg_rem = 2'd2;
                default: ;
            endcase
        end
        return n;
    endfunction

    always_comb begin
        mid = exec_slot(cur, mem_data_in[3:0]);
        nxt = exec_slot(mid, mem_data_in[7:4]);
`ifndef MISAO_LK16_EN
        nxt.acc[15:8] = 8'h00;
        nxt.rs0[15:8] = 8'h00;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= '0;
            pc  <= '0;
        end else begin
            cur <= nxt;
            pc  <= pc + 15'd1;
        end
    end

    assign mem_enable_read  = ~rst;
    assign mem_enable_write = 1'b0;
    assign mem_rw           = 1'b0;
    assign mem_addr         = pc;
    assign mem_data_out     = cur.acc[7:0];
    assign test_data        = cur.acc;
    assign test_carry       = cur.c;

endmodule

// File: tb/tb_misao.sv
// Self-checking bench for misao: directed programs plus randomized byte streams against a nibble-level model.
module tb_misao;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_enable_read;
  logic        mem_enable_write;
  logic [7:0]  mem_data_in;
  logic [14:0] mem_addr;
  logic        mem_rw;
  logic [7:0]  mem_data_out;
  logic [15:0] test_data;
  logic        test_carry;

`ifdef MISAO_LK16_EN
  localparam bit LK16_EN = 1'b1;
`else
  localparam bit LK16_EN = 1'b0;
`endif

  logic [7:0]  prog [0:32767];
  logic [7:0]  pq[$];
  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  // model state
  int m_acc, m_rs0, m_c, m_cfg, m_pc, m_ldi_left, m_ldi_k, m_cfg_left, m_cfg_lo;
  bit m_xop;

  misao dut (
    .clk(clk), .rst(rst),
    .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
    .mem_data_in(mem_data_in), .mem_addr(mem_addr), .mem_rw(mem_rw),
    .mem_data_out(mem_data_out), .test_data(test_data), .test_carry(test_carry)
  );

  assign mem_data_in = prog[mem_addr];

  always #5 clk = ~clk;

  function automatic void m_reset();
    m_acc = 0; m_rs0 = 0; m_c = 0; m_cfg = 0; m_pc = 0;
    m_ldi_left = 0; m_ldi_k = 0; m_cfg_left = 0; m_cfg_lo = 0; m_xop = 0;
  endfunction

  function automatic int m_width();
    case (m_cfg % 4)
      0: return 4;
      1: return 8;
      default: return LK16_EN ? 16 : 8;
    endcase
  endfunction

  function automatic void m_nibble(input int n);
    int w, md, a, b, s, op, cen, tmp;
    w = m_width(); md = 1 << w; a = m_acc % md; b = m_rs0 % md;
    cen = (m_cfg / 8) % 2;
    if (m_cfg_left == 2) begin m_cfg_lo = n; m_cfg_left = 1; return; end
    if (m_cfg_left == 1) begin m_cfg = n * 16 + m_cfg_lo; m_cfg_left = 0; return; end
    if (m_ldi_left > 0) begin
      if (m_ldi_k == 0) m_acc = n;
      else m_acc = m_acc + n * (1 << (4 * m_ldi_k));
      m_ldi_k++; m_ldi_left--;
      return;
    end
    op = m_xop ? n + 16 : n;
    m_xop = 0;
    case (op)
      1: m_xop = 1;
      2: begin m_ldi_left = w / 4; m_ldi_k = 0; end
      3: begin tmp = m_acc; m_acc = m_rs0; m_rs0 = tmp; end
      4: begin s = a + b; m_c = (s >= md); m_acc = s % md; end
      5: begin s = a + 1; m_c = (s >= md); m_acc = s % md; end
      6: begin m_acc = a & b; m_c = 0; end
      7: begin m_acc = a | b; m_c = 0; end
      8: begin m_c = (a >= md / 2); m_acc = (a * 2) % md; end
      9: m_c = 0;
      20: begin m_c = (a < b) ? cen : 1 - cen; m_acc = (a - b + md) % md; end
      21: begin m_c = (a < 1) ? cen : 1 - cen; m_acc = (a - 1 + md) % md; end
      22: begin m_acc = md - 1 - a; m_c = 1 - m_c; end
      23: begin m_acc = a ^ b; m_c = 0; end
      24: begin m_c = a % 2; m_acc = a / 2; end
      25: m_cfg_left = 2;
      default: ;
    endcase
  endfunction

  task automatic load_pq();
    for (int i = 0; i < 32768; i++) prog[i] = 8'h00;
    for (int i = 0; i < pq.size(); i++) prog[i] = pq[i];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  // advances DUT and model one byte per cycle, queuing expected and observed state
  task automatic run_cycles(input int n);
    int bt;
    for (int i = 0; i < n; i++) begin
      bt = int'(prog[m_pc]);
      m_nibble(bt % 16);
      m_nibble(bt / 16);
      m_pc = (m_pc + 1) % 32768;
      exp_q.push_back({m_pc[14:0], m_c[0], m_acc[15:0], m_acc[7:0]});
      @(posedge clk);
      @(negedge clk);
      obs_q.push_back({mem_addr, test_carry, test_data, mem_data_out});
    end
  endtask

  task automatic test_reset();
    pq = '{};
    load_pq();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mem_enable_read !== 1'b0 || mem_enable_write !== 1'b0 || mem_rw !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_enables: got rd=%b wr=%b rw=%b, want 0 0 0", mem_enable_read, mem_enable_write, mem_rw);
    end
    rst = 1'b0;
    m_reset();
    #1;
    n_cmp++;
    if (mem_addr !== 15'd0 || test_data !== 16'd0 || test_carry !== 1'b0 || mem_enable_read !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got pc=%h acc=%h c=%b rd=%b, want 0 0 0 1", mem_addr, test_data, test_carry, mem_enable_read);
    end
  endtask

  task automatic test_ul_add_chain();
    logic [39:0] e, o, got[$];
    int idx[5]; logic [15:0] ea[5]; logic ec[5];
    pq = '{8'h91, 8'h4C, 8'h52, 8'h23, 8'h43, 8'h40, 8'h40, 8'h90, 8'h50};
    load_pq();
    do_reset();
    run_cycles(9);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); got.push_back(o); n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL ul_add_model byte %0d: got pc=%h c=%b acc=%h dout=%h want pc=%h c=%b acc=%h dout=%h",
                 got.size() - 1, o[39:25], o[24], o[23:8], o[7:0], e[39:25], e[24], e[23:8], e[7:0]);
      end
    end
    idx = '{4, 5, 6, 7, 8}; ea = '{16'h8, 16'hD, 16'h2, 16'h2, 16'h3}; ec = '{0, 0, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (got[idx[i]][23:8] !== ea[i] || got[idx[i]][24] !== ec[i]) begin
        n_fail++;
        $display("FAIL ul_add byte %0d: got acc=%h c=%b want acc=%h c=%b", idx[i], got[idx[i]][23:8], got[idx[i]][24], ea[i], ec[i]);
      end
    end
  endtask

  task automatic test_ul_sub_logic();
    logic [39:0] e, o, got[$];
    int idx[7]; logic [15:0] ea[7]; logic ec[7];
    // SUB borrow program (bytes 0-5), then logic program after a reset
    pq = '{8'h91, 8'h4C, 8'h52, 8'h23, 8'h13, 8'h04};
    load_pq();
    do_reset();
    run_cycles(6);
    pq = '{8'hC2, 8'h23, 8'h6A, 8'h07, 8'h71, 8'h61, 8'h08, 8'h81};
    load_pq();
    do_reset();
    run_cycles(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); got.push_back(o); n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL ul_sub_logic_model step %0d: got pc=%h c=%b acc=%h dout=%h want pc=%h c=%b acc=%h dout=%h",
                 got.size() - 1, o[39:25], o[24], o[23:8], o[7:0], e[39:25], e[24], e[23:8], e[7:0]);
      end
    end
    idx = '{5, 8, 9, 10, 11, 12, 13};
    ea = '{16'hE, 16'h8, 16'hC, 16'h0, 16'hF, 16'hE, 16'h7};
    ec = '{1, 0, 0, 0, 1, 1, 0};
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (got[idx[i]][23:8] !== ea[i] || got[idx[i]][24] !== ec[i]) begin
        n_fail++;
        $display("FAIL ul_sub_logic step %0d: got acc=%h c=%b want acc=%h c=%b", idx[i], got[idx[i]][23:8], got[idx[i]][24], ea[i], ec[i]);
      end
    end
  endtask

  task automatic test_wide();
    logic [39:0] e, o, got[$];
    int idx[8]; logic [15:0] ea[8]; logic ec[8];
    // LK8 program: steps 0-6; LK16 program: steps 7-20
    pq = '{8'h91, 8'h01, 8'h12, 8'h30, 8'hF2, 8'h0F, 8'h04};
    load_pq();
    do_reset();
    run_cycles(7);
    pq = '{8'h91, 8'h02, 8'h12, 8'h00, 8'h00, 8'h13, 8'h26, 8'hFF, 8'hFF, 8'h04, 8'h12, 8'h00, 8'h80, 8'h81};
    load_pq();
    do_reset();
    run_cycles(14);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); got.push_back(o); n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wide_model step %0d: got pc=%h c=%b acc=%h dout=%h want pc=%h c=%b acc=%h dout=%h",
                 got.size() - 1, o[39:25], o[24], o[23:8], o[7:0], e[39:25], e[24], e[23:8], e[7:0]);
      end
    end
    idx = '{4, 5, 6, 11, 15, 16, 19, 20};
    ea = '{16'h000F, 16'h00FF, 16'h0000, 16'h0001, LK16_EN ? 16'hFFFF : 16'h00FF, 16'h0000, 16'h0002, 16'h0001};
    ec = '{0, 0, 1, 0, 1, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got[idx[i]][23:8] !== ea[i] || got[idx[i]][24] !== ec[i]) begin
        n_fail++;
        $display("FAIL wide step %0d: got acc=%h c=%b want acc=%h c=%b", idx[i], got[idx[i]][23:8], got[idx[i]][24], ea[i], ec[i]);
      end
    end
  endtask

  task automatic test_dec_cen_reset();
    logic [39:0] e, o, got[$];
    pq = '{8'h91, 8'h4C, 8'h32, 8'h51, 8'h91, 8'h44, 8'h51};
    load_pq();
    do_reset();
    run_cycles(7);
    // reset in the middle of an LK16 LDI and in the middle of a CFG
    pq = '{8'h91, 8'h02, 8'h52, 8'h45, 8'h33};
    load_pq();
    do_reset();
    run_cycles(3);
    do_reset();
    n_cmp++;
    if (test_data !== 16'h0000 || mem_addr !== 15'd0 || test_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_ldi: got acc=%h pc=%h c=%b want 0 0 0", test_data, mem_addr, test_carry);
    end
    run_cycles(5);
    do_reset();
    run_cycles(1);
    do_reset();
    run_cycles(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); got.push_back(o); n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL dec_cen_model step %0d: got pc=%h c=%b acc=%h dout=%h want pc=%h c=%b acc=%h dout=%h",
                 got.size() - 1, o[39:25], o[24], o[23:8], o[7:0], e[39:25], e[24], e[23:8], e[7:0]);
      end
    end
    n_cmp++;
    if (got[3][23:8] !== 16'h2 || got[3][24] !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_cen1: got acc=%h c=%b want acc=2 c=0", got[3][23:8], got[3][24]);
    end
    n_cmp++;
    if (got[6][23:8] !== 16'h1 || got[6][24] !== 1'b1) begin
      n_fail++;
      $display("FAIL dec_cen0: got acc=%h c=%b want acc=1 c=1", got[6][23:8], got[6][24]);
    end
  endtask

  task automatic test_random();
    logic [39:0] e, o;
    int k, i;
    for (int round = 0; round < 4; round++) begin
      pq = '{};
      i = 0;
      while (i < 600) begin
        if ($urandom_range(0, 7) == 0) begin
          pq.push_back(8'h91);
          pq.push_back(8'($urandom_range(0, 255)));
          i += 2;
        end else begin
          pq.push_back(8'($urandom_range(0, 255)));
          i++;
        end
      end
      load_pq();
      do_reset();
      for (int seg = 0; seg < 5; seg++) begin
        run_cycles($urandom_range(20, 100));
        if ($urandom_range(0, 2) == 0) do_reset();
      end
    end
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random step %0d: got pc=%h c=%b acc=%h dout=%h want pc=%h c=%b acc=%h dout=%h",
                 k, o[39:25], o[24], o[23:8], o[7:0], e[39:25], e[24], e[23:8], e[7:0]);
      end
      k++;
    end
  endtask

  task automatic test_pc_wrap();
    logic [39:0] e, o, got[$];
    pq = '{};
    load_pq();
    do_reset();
    run_cycles(32769);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); got.push_back(o); n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL pc_wrap_model step %0d: got pc=%h acc=%h want pc=%h acc=%h",
                 got.size() - 1, o[39:25], o[23:8], e[39:25], e[23:8]);
      end
    end
    n_cmp++;
    if (got[32766][39:25] !== 15'h7FFF || got[32767][39:25] !== 15'h0000) begin
      n_fail++;
      $display("FAIL pc_wrap: got pc=%h then %h want 7fff then 0000", got[32766][39:25], got[32767][39:25]);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_ul_add_chain();
    test_ul_sub_logic();
    test_wide();
    test_dec_cen_reset();
    test_random();
    test_pc_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
